enemy_group: RTL and testbench

- Parametrised multi-enemy motion controller for the Bomber-Man playfield; drives NUM_ENEMIES enemies from one time-multiplexed FSM.
- Per-enemy collision bounce, playfield clamping, deterministic random re-steering, kill/alive tracking and a speed-boost mode.
- Sits between the collision/hit-edge logic and the enemy draw/mux blocks; one instance replaces per-enemy movers.

---
 rtl/enemy_pkg.sv | 41 ++++
 rtl/enemy_steer.sv | 54 +++++
 rtl/enemy_group.sv | 218 +++++++++++++++++++++
 tb/tb_enemy_group.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// enemy_pkg: shared definitions for the multi-enemy motion controller.
//   - one-hot direction codes and opposite()
//   - fixed-point shift and playfield limits
//   - controller state encoding
package enemy_pkg;

  localparam logic [3:0] TOP    = 4'b0100;
  localparam logic [3:0] RIGHT  = 4'b0010;
  localparam logic [3:0] LEFT   = 4'b1000;
  localparam logic [3:0] BOTTOM = 4'b0001;

  // Positions are kept as pixel * 64
  localparam int FIXED_POINT_SHIFT = 6;

  localparam int X_FRAME_LEFT   = 15;
  localparam int X_FRAME_RIGHT  = 623;
  localparam int Y_FRAME_TOP    = 48;
  localparam int Y_FRAME_BOTTOM = 464;
  localparam int OBJECT_SIZE    = 32;

  typedef enum logic [2:0] {
    IDLE_ST    = 3'd0,
    COLLECT_ST = 3'd1,
    FRAME_ST   = 3'd2,
    BOUNCE_ST  = 3'd3,
    MOVE_ST    = 3'd4,
    LIMIT_ST   = 3'd5,
    DONE_ST    = 3'd6
  } state_t;

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      TOP:     return BOTTOM;
      BOTTOM:  return TOP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/enemy_steer.sv
// enemy_steer: combinational direction chooser used whenever an enemy is
// blocked (collision bounce or playfield wall).
//   blocked    : one-hot direction that must not be taken
//   random_num : pseudo-random source, 00 BOTTOM, 01 TOP, 10 LEFT, 11 RIGHT
//   dx, dy     : player minus enemy, pixels (only with ENEMY_CHASE_MODE_EN)
//   new_dir    : chosen one-hot direction
// With ENEMY_CHASE_MODE_EN defined the enemy heads along the axis with the
// larger distance to the player (X on ties); otherwise it steers randomly.
module enemy_steer import enemy_pkg::*; (
  input  logic [3:0]        blocked,
  input  logic [1:0]        random_num,
`ifdef ENEMY_CHASE_MODE_EN
  input  logic signed [11:0] dx,
  input  logic signed [11:0] dy,
`endif
  output logic [3:0]        new_dir
);

  logic [3:0] cand;
  logic [3:0] rnd_dir;

  always_comb begin
    case (random_num)
      2'b00:   cand = BOTTOM;
      2'b01:   cand = TOP;
      2'b10:   cand = LEFT;
      default: cand = RIGHT;
    endcase
    rnd_dir = (cand == blocked) ? opposite(blocked) : cand;
  end

`ifdef ENEMY_CHASE_MODE_EN
  logic [11:0] adx;
  logic [11:0] ady;
  logic [3:0]  chase;

  always_comb begin
    adx = dx[11] ? 12'(-dx) : 12'(dx);
    ady = dy[11] ? 12'(-dy) : 12'(dy);
    if (dx == 12'sd0 && dy == 12'sd0) begin
      chase = rnd_dir;
    end else if (adx >= ady) begin
      chase = dx[11] ? LEFT : RIGHT;
    end else begin
      // screen Y grows downwards
      chase = dy[11] ? TOP : BOTTOM;
    end
    new_dir = (chase == blocked) ? rnd_dir : chase;
  end
`else
  assign new_dir = rnd_dir;
`endif

endmodule

// File: rtl/enemy_group.sv
// enemy_group: one time-multiplexed FSM moving NUM_ENEMIES enemies.
// Each frame: collect collisions/kills, then per enemy BOUNCE -> MOVE ->
// LIMIT (3 cycles each, dead enemies still take their slot), then DONE.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   startOfFrame        : one-cycle frame strobe, honoured only while collecting
//   game_on             : 1 = run, 0 = return to spawn after the current frame
//   random_num          : re-steer source
//   speed_boost         : doubles the speed, sampled once per frame
//   collision, HitEdgeCode, kill : per-enemy strobes, enemy i at slice i
//   topLeftX, topLeftY  : pixel positions, 11 bits per enemy
//   alive               : per-enemy active flag
//   frame_done          : one-cycle pulse once every enemy is updated
//   dbg_state           : current FSM state
//   playerX, playerY    : player pixel position (ENEMY_CHASE_MODE_EN only)
// Strobes are plain single-cycle levels sampled at clk; no handshake.
module enemy_group import enemy_pkg::*; #(
  parameter int         NUM_ENEMIES  = 4,
  parameter int         INITIAL_X    = 15,
  parameter int         INITIAL_Y    = 48,
  parameter int         SPAWN_STEP_X = 128,
  parameter int         SPEED        = 64,
  parameter logic [3:0] START_DIR    = 4'b0001
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startOfFrame,
  input  logic                       game_on,
  input  logic [1:0]                 random_num,
  input  logic                       speed_boost,
  input  logic [NUM_ENEMIES-1:0]     collision,
  input  logic [4*NUM_ENEMIES-1:0]   HitEdgeCode,
  input  logic [NUM_ENEMIES-1:0]     kill,
`ifdef ENEMY_CHASE_MODE_EN
  input  logic signed [10:0]         playerX,
  input  logic signed [10:0]         playerY,
`endif
  output logic [11*NUM_ENEMIES-1:0]  topLeftX,
  output logic [11*NUM_ENEMIES-1:0]  topLeftY,
  output logic [NUM_ENEMIES-1:0]     alive,
  output logic                       frame_done,
  output state_t                     dbg_state
);

  localparam int IDX_W   = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int POS_ONE = 1 << FIXED_POINT_SHIFT;
  localparam logic signed [31:0] X_MIN = 32'(X_FRAME_LEFT * POS_ONE);
  localparam logic signed [31:0] X_MAX = 32'((X_FRAME_RIGHT - OBJECT_SIZE) * POS_ONE);
  localparam logic signed [31:0] Y_MIN = 32'(Y_FRAME_TOP * POS_ONE);
  localparam logic signed [31:0] Y_MAX = 32'((Y_FRAME_BOTTOM - OBJECT_SIZE) * POS_ONE);
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(NUM_ENEMIES - 1);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic signed [31:0]     v;
  logic signed [31:0]     pos_x [NUM_ENEMIES];
  logic signed [31:0]     pos_y [NUM_ENEMIES];
  logic [3:0]             dir   [NUM_ENEMIES];
  logic [3:0]             hit_reg [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0] hit_flag;

  function automatic logic signed [31:0] spawn_x(input int i);
    return 32'((INITIAL_X + i * SPAWN_STEP_X) * POS_ONE);
  endfunction

  function automatic logic signed [31:0] step_x(input logic [3:0] d, input logic signed [31:0] s);
    return (d == RIGHT) ? s : (d == LEFT) ? -s : 32'sd0;
  endfunction

  function automatic logic signed [31:0] step_y(input logic [3:0] d, input logic signed [31:0] s);
    return (d == BOTTOM) ? s : (d == TOP) ? -s : 32'sd0;
  endfunction

  // Datapath for the enemy currently selected by idx
  logic signed [31:0] cur_x, cur_y, bounce_x, bounce_y, move_x, move_y;
  logic [3:0]         cur_hit, cur_dir, steer_blocked, steer_dir;
  logic               hit_valid, x_low, x_high, y_low, y_high;

  always_comb begin
    cur_x     = pos_x[idx];
    cur_y     = pos_y[idx];
    cur_hit   = hit_reg[idx];
    cur_dir   = dir[idx];
    hit_valid = (cur_hit == TOP) || (cur_hit == RIGHT) ||
                (cur_hit == LEFT) || (cur_hit == BOTTOM);
    // back off away from the edge that was hit
    bounce_x  = cur_x + step_x(opposite(cur_hit), v);
    bounce_y  = cur_y + step_y(opposite(cur_hit), v);
    move_x    = cur_x + step_x(cur_dir, v);
    move_y    = cur_y + step_y(cur_dir, v);
    x_low     = cur_x < X_MIN;
    x_high    = cur_x > X_MAX;
    y_low     = cur_y < Y_MIN;
    y_high    = cur_y > Y_MAX;
    // a Y clamp overrides an X clamp in the same cycle
    if (state == BOUNCE_ST) steer_blocked = cur_hit;
    else if (y_low)         steer_blocked = TOP;
    else if (y_high)        steer_blocked = BOTTOM;
    else if (x_low)         steer_blocked = LEFT;
    else                    steer_blocked = RIGHT;
  end

`ifdef ENEMY_CHASE_MODE_EN
  logic signed [10:0] cur_px, cur_py;
  logic signed [11:0] dx, dy;
  always_comb begin
    cur_px = cur_x[FIXED_POINT_SHIFT +: 11];
    cur_py = cur_y[FIXED_POINT_SHIFT +: 11];
    dx     = {playerX[10], playerX} - {cur_px[10], cur_px};
    dy     = {playerY[10], playerY} - {cur_py[10], cur_py};
  end
`endif

  enemy_steer u_steer (
    .blocked    (steer_blocked),
    .random_num (random_num),
`ifdef ENEMY_CHASE_MODE_EN
    .dx         (dx),
    .dy         (dy),
`endif
    .new_dir    (steer_dir)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE_ST;
      idx        <= '0;
      v          <= 32'(SPEED);
      frame_done <= 1'b0;
      hit_flag   <= '0;
      alive      <= '1;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        pos_x[i]   <= spawn_x(i);
        pos_y[i]   <= 32'(INITIAL_Y * POS_ONE);
        dir[i]     <= START_DIR;
        hit_reg[i] <= 4'b0;
      end
    end else begin
      frame_done <= 1'b0;
      if (state != IDLE_ST) alive <= alive & ~kill;
      case (state)
        IDLE_ST: begin
          alive    <= '1;
          hit_flag <= '0;
          for (int i = 0; i < NUM_ENEMIES; i++) begin
            pos_x[i]   <= spawn_x(i);
            pos_y[i]   <= 32'(INITIAL_Y * POS_ONE);
            dir[i]     <= START_DIR;
            hit_reg[i] <= 4'b0;
          end
          if (game_on) state <= COLLECT_ST;
        end
        COLLECT_ST: begin
          // only the first collision of the frame counts
          for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (alive[i] && collision[i] && !hit_flag[i]) begin
              hit_reg[i]  <= HitEdgeCode[4*i +: 4];
              hit_flag[i] <= 1'b1;
            end
          end
          if (startOfFrame) state <= FRAME_ST;
        end
        FRAME_ST: begin
          v     <= speed_boost ? 32'(2 * SPEED) : 32'(SPEED);
          idx   <= '0;
          state <= BOUNCE_ST;
        end
        BOUNCE_ST: begin
          if (alive[idx] && hit_valid) begin
            pos_x[idx] <= bounce_x;
            pos_y[idx] <= bounce_y;
            dir[idx]   <= steer_dir;
          end
          hit_reg[idx]  <= 4'b0;
          hit_flag[idx] <= 1'b0;
          state         <= MOVE_ST;
        end
        MOVE_ST: begin
          if (alive[idx]) begin
            pos_x[idx] <= move_x;
            pos_y[idx] <= move_y;
          end
          state <= LIMIT_ST;
        end
        LIMIT_ST: begin
          if (alive[idx]) begin
            if (x_low)  pos_x[idx] <= X_MIN;
            if (x_high) pos_x[idx] <= X_MAX;
            if (y_low)  pos_y[idx] <= Y_MIN;
            if (y_high) pos_y[idx] <= Y_MAX;
            if (x_low || x_high || y_low || y_high) dir[idx] <= steer_dir;
          end
          if (idx == LAST) begin
            state      <= DONE_ST;
            frame_done <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= BOUNCE_ST;
          end
        end
        DONE_ST: state <= game_on ? COLLECT_ST : IDLE_ST;
        default: state <= IDLE_ST;
      endcase
    end
  end

  always_comb begin
    topLeftX = '0;
    topLeftY = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      topLeftX[11*i +: 11] = pos_x[i][FIXED_POINT_SHIFT +: 11];
      topLeftY[11*i +: 11] = pos_y[i][FIXED_POINT_SHIFT +: 11];
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_enemy_group.sv
// tb_enemy_group: directed, table-driven bench for enemy_group with four
// enemies starting RIGHT. Each table record is one frame: pre-frame
// collision/kill pulses and the expected positions/alive after the frame.
module tb_enemy_group;
  import enemy_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            startOfFrame;
  logic            game_on;
  logic [1:0]      random_num;
  logic            speed_boost;
  logic [N-1:0]    collision;
  logic [4*N-1:0]  HitEdgeCode;
  logic [N-1:0]    kill;
  logic [11*N-1:0] topLeftX;
  logic [11*N-1:0] topLeftY;
  logic [N-1:0]    alive;
  logic            frame_done;
  state_t          dbg_state;

  enemy_group #(.NUM_ENEMIES(N), .START_DIR(4'b0010)) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .game_on      (game_on),
    .random_num   (random_num),
    .speed_boost  (speed_boost),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .kill         (kill),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .alive        (alive),
    .frame_done   (frame_done),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [10:0] px(input logic [11*N-1:0] bus, input int i);
    return bus[11*i +: 11];
  endfunction

  // stimulus table
  typedef struct packed {
    logic [1:0]       rnd;
    logic             boost;
    logic             gon;
    logic [3:0]       c0_mask;
    logic [3:0]       c0_code;
    logic [3:0]       c1_mask;
    logic [3:0]       c1_code;
    logic [3:0]       kill_mask;
    logic             sof_c0;   // enemy0 BOTTOM collision in the startOfFrame cycle
    logic             noise;    // collision + startOfFrame injected mid-update
    logic [3:0][10:0] ex;
    logic [3:0][10:0] ey;
    logic [3:0]       ealive;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [1:0] rnd, input logic boost, input logic gon,
    input logic [3:0] c0m, input logic [3:0] c0c,
    input logic [3:0] c1m, input logic [3:0] c1c,
    input logic [3:0] km, input logic sc0, input logic nz,
    input int x0, input int x1, input int x2, input int x3,
    input int y0, input int y1, input int y2, input int y3,
    input logic [3:0] al);
    vec_t r;
    r.rnd = rnd; r.boost = boost; r.gon = gon;
    r.c0_mask = c0m; r.c0_code = c0c; r.c1_mask = c1m; r.c1_code = c1c;
    r.kill_mask = km; r.sof_c0 = sc0; r.noise = nz;
    r.ex[0] = 11'(x0); r.ex[1] = 11'(x1); r.ex[2] = 11'(x2); r.ex[3] = 11'(x3);
    r.ey[0] = 11'(y0); r.ey[1] = 11'(y1); r.ey[2] = 11'(y2); r.ey[3] = 11'(y3);
    r.ealive = al;
    return r;
  endfunction

  // driver: one frame, returns cycles from startOfFrame to frame_done (0 = timeout)
  task automatic run_frame(input vec_t fv, output int lat);
    random_num   = fv.rnd;
    speed_boost  = fv.boost;
    startOfFrame = 1'b1;
    if (fv.sof_c0) begin
      collision   = 4'b0001;
      HitEdgeCode = {4{BOTTOM}};
    end
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin startOfFrame = 1'b0; collision = '0; end
      if (fv.noise && n == 4) begin
        collision    = 4'b0010;
        HitEdgeCode  = {4{RIGHT}};
        startOfFrame = 1'b1;
      end
      if (fv.noise && n == 5) begin collision = '0; startOfFrame = 1'b0; end
      if (frame_done) begin lat = n; break; end
    end
  endtask

  task automatic pulse(input logic [3:0] cm, input logic [3:0] code, input logic [3:0] km);
    collision   = cm;
    HitEdgeCode = {4{code}};
    kill        = km;
    @(posedge clk); #1;
    collision = '0;
    kill      = '0;
  endtask

  initial begin
    int lat;
    reset = 1'b1; startOfFrame = 1'b0; game_on = 1'b0; random_num = 2'b00;
    speed_boost = 1'b0; collision = '0; HitEdgeCode = '0; kill = '0;

    //                 rnd  bst gon c0m     c0c     c1m     c1c    kill    sc0 nz   X0  X1   X2   X3   Y0  Y1  Y2  Y3  alive
    vecs[0]  = mk(2'd0, 0, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  16, 144, 272, 400, 48, 48, 48, 48, 4'hF);
    vecs[1]  = mk(2'd0, 0, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  17, 145, 273, 401, 48, 48, 48, 48, 4'hF);
    vecs[2]  = mk(2'd0, 0, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  18, 146, 274, 402, 48, 48, 48, 48, 4'hF);
    vecs[3]  = mk(2'd3, 0, 1, 4'b0010, RIGHT,  4'b0000, 4'd0,  4'b0000, 0, 0,  19, 144, 275, 403, 48, 48, 48, 48, 4'hF);
    vecs[4]  = mk(2'd0, 0, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  20, 143, 276, 404, 48, 48, 48, 48, 4'hF);
    vecs[5]  = mk(2'd1, 0, 1, 4'b0001, BOTTOM, 4'b0000, 4'd0,  4'b0000, 0, 0,  20, 142, 277, 405, 48, 48, 48, 48, 4'hF);
    vecs[6]  = mk(2'd0, 0, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  20, 141, 278, 406, 49, 48, 48, 48, 4'hF);
    vecs[7]  = mk(2'd0, 1, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  20, 139, 280, 408, 51, 48, 48, 48, 4'hF);
    vecs[8]  = mk(2'd0, 1, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0100, 0, 0,  20, 137, 280, 410, 53, 48, 48, 48, 4'hB);
    vecs[9]  = mk(2'd0, 0, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  20, 136, 280, 411, 54, 48, 48, 48, 4'hB);
    vecs[10] = mk(2'd0, 0, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  20, 135, 280, 412, 55, 48, 48, 48, 4'hB);
    vecs[11] = mk(2'd3, 0, 1, 4'b1000, TOP,    4'b1000, LEFT,  4'b0000, 0, 0,  20, 134, 280, 413, 56, 48, 48, 49, 4'hB);
    vecs[12] = mk(2'd2, 0, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 1, 1,  19, 133, 280, 414, 55, 48, 48, 49, 4'hB);
    vecs[13] = mk(2'd0, 0, 1, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  18, 132, 280, 415, 55, 48, 48, 49, 4'hB);
    vecs[14] = mk(2'd0, 0, 0, 4'b0000, 4'd0,   4'b0000, 4'd0,  4'b0000, 0, 0,  17, 131, 280, 416, 55, 48, 48, 49, 4'hB);

    // reset block
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, IDLE_ST);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_alive", alive, 4'hF);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_x%0d", i), px(topLeftX, i), 15 + 128 * i);
      check($sformatf("rst_y%0d", i), px(topLeftY, i), 48);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    game_on = 1'b1;

    // table-driven frames
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;   // enter COLLECT_ST
      game_on = vecs[k].gon;
      if (vecs[k].c0_mask != 4'b0)   pulse(vecs[k].c0_mask, vecs[k].c0_code, 4'b0);
      if (vecs[k].c1_mask != 4'b0)   pulse(vecs[k].c1_mask, vecs[k].c1_code, 4'b0);
      if (vecs[k].kill_mask != 4'b0) pulse(4'b0, 4'd0, vecs[k].kill_mask);
      run_frame(vecs[k], lat);
      check($sformatf("f%0d_latency", k), lat, 14);
      for (int i = 0; i < N; i++) exp_q.push_back(vecs[k].ex[i]);
      for (int i = 0; i < N; i++) exp_q.push_back(vecs[k].ey[i]);
      for (int i = 0; i < N; i++) check($sformatf("f%0d_x%0d", k, i), px(topLeftX, i), exp_q.pop_front());
      for (int i = 0; i < N; i++) check($sformatf("f%0d_y%0d", k, i), px(topLeftY, i), exp_q.pop_front());
      check($sformatf("f%0d_alive", k), alive, vecs[k].ealive);
    end

    // game_on low: back to IDLE_ST and respawn, kill ignored there
    @(posedge clk); #1;
    check("reload_state", dbg_state, IDLE_ST);
    @(posedge clk); #1;
    check("reload_x3", px(topLeftX, 3), 399);
    check("reload_y3", px(topLeftY, 3), 48);
    check("reload_x0", px(topLeftX, 0), 15);
    check("reload_alive", alive, 4'hF);
    pulse(4'b0, 4'd0, 4'b0001);
    check("idle_kill_ignored", alive, 4'hF);

    // restart: directions reloaded to RIGHT for every enemy
    game_on = 1'b1;
    @(posedge clk); #1;
    check("restart_state", dbg_state, COLLECT_ST);
    run_frame(mk(2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF), lat);
    check("restart_latency", lat, 14);
    for (int i = 0; i < N; i++) begin
      check($sformatf("restart_x%0d", i), px(topLeftX, i), 16 + 128 * i);
      check($sformatf("restart_y%0d", i), px(topLeftY, i), 48);
    end

    // asynchronous reset between clock edges
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_x0", px(topLeftX, 0), 15);
    check("async_rst_state", dbg_state, IDLE_ST);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
